tt_gate_sched: RTL and testbench
================================

TT_GATE_SCHED -- requirements
Module: tt_gate_sched

Interface
- REQ-001 Parameter N_L, default 2: number of low-priority (RC) channels.
- REQ-002 Parameter CW, default 12: cycle-counter width.
- REQ-003 Parameter CYCLE_LEN, default 12'h100: schedule cycle length in clocks.
- REQ-004 Parameter TT_START, default 12'h040: first cycle count of the TT window.
- REQ-005 Parameter TT_LEN, default 12'h020: TT window length in clocks.
- REQ-006 Parameter GUARD, default 12'h010: guard-band length immediately before TT_START.
- REQ-007 clk  in  1  single clock; all state changes on rising edge.
- REQ-008 rst_n  in  1  reset, asynchronous, active-low.
- REQ-009 sched_en  in  1  1 = schedule running; 0 = hold in IDLE.
- REQ-010 bool_go_H  in  1  TT queue-server go pulse, monitor only.
- REQ-011 bool_go_L  in  N_L  per-channel go pulse; starts a low transfer.
- REQ-012 done_L  in  N_L  per-channel one-cycle pulse; ends a low transfer.
- REQ-013 ena_n_H  out  1  active-low enable to the TT queue server.
- REQ-014 ena_n_L  out  N_L  active-low per-channel enables to the low-priority emulators/servers.
- REQ-015 phase  out  2  current phase; encoding from the shared package.
- REQ-016 cycle_cnt  out  CW  current position in the schedule cycle.
- REQ-017 overrun  out  1  one-cycle pulse when TT starts with a low transfer in flight.

Function
- REQ-018 cycle_cnt SHALL count 0..CYCLE_LEN-1 while sched_en=1, wrap CYCLE_LEN-1 -> 0, and hold at 0 while sched_en=0.
- REQ-019 The FSM SHALL have four states: IDLE, OPEN, GUARD and TT; phase encodings are 00, 01, 10 and 11 respectively.
- REQ-020 State SHALL be registered and aligned with cycle_cnt:
  - TT when cycle_cnt is in [TT_START, TT_START+TT_LEN);
  - GUARD when cycle_cnt is in [TT_START-GUARD, TT_START), modulo CYCLE_LEN;
  - OPEN otherwise.
- REQ-021 sched_en falling SHALL force IDLE and clear cycle_cnt on the next edge.
- REQ-022 sched_en rising SHALL give cycle_cnt=0 on the next edge, in the state mapped to count 0.
- REQ-023 ena_n_H SHALL be 0 only in TT.
- REQ-024 In OPEN, ena_n_L SHALL be all 0.
- REQ-025 In GUARD, ena_n_L[i] SHALL be 0 only if busy[i]=1, so no new low transfer starts.
- REQ-026 In TT and IDLE, ena_n_L SHALL be all 1.
- REQ-027 busy[i] SHALL set on bool_go_L[i] and clear on done_L[i].
  - Simultaneous go and done on the same cycle: busy[i] ends at 1.
  - done_L with busy=0 is ignored.
- REQ-028 On entry to TT with any busy[i]=1, overrun SHALL pulse once.
  - ena_n_H still goes 0 at TT_START; TT is never delayed.
  - ena_n_L[i] goes 1 even while busy.
- REQ-029 bool_go_L[i] arriving while ena_n_L[i]=1 SHALL still set busy[i].
- REQ-030 bool_go_H is monitor-only and changes no scheduler state.
- REQ-031 All outputs SHALL be registered; zero combinational input-to-output paths.
- REQ-032 Elaboration SHALL error unless GUARD+TT_LEN < CYCLE_LEN and TT_START+TT_LEN <= CYCLE_LEN.

Reset
- REQ-033 rst_n=0 SHALL immediately force the following, independent of clk and regardless of the current phase:
  - state=IDLE, cycle_cnt=0, busy=0;
  - ena_n_H=1, ena_n_L all 1;
  - phase=00, overrun=0.
- REQ-034 After rst_n rises, operation SHALL resume on the first clk edge with sched_en=1.

Configuration
- REQ-035 Macro TT_GATE_OVERRUN_CNT_EN, when defined, SHALL add:
  - output overrun_cnt, 8 bits;
  - incremented on each overrun pulse, saturating at 8'hFF;
  - cleared by reset.
- REQ-036 Without the macro, port overrun_cnt and its logic SHALL be absent; all other behaviour is identical.

Structure
- REQ-037 Package fpq_sched_pkg SHALL hold:
  - phase encodings;
  - traffic-class constants (PCF=00, TT=01, BE=10, RC=11);
  - the default CW.
- REQ-038 Sub-module cycle_timer (counter, wrap, sched_en hold) SHALL be instantiated once; the FSM and busy tracking stay in tt_gate_sched.

Verification
- REQ-039 Defaults, sched_en=1 after reset -> phase sequence:
  - OPEN at counts 0..0x2F;
  - GUARD at 0x30..0x3F;
  - TT at 0x40..0x5F;
  - OPEN again at 0x60; wrap at 0xFF->0.
- REQ-040 Low channel 0 go at count 0x20, done at 0x38:
  - ena_n_L[0]=0 through 0x37; ena_n_L[1]=1 from 0x30;
  - no overrun pulse.
- REQ-041 Channel 1 go at 0x3C with done at 0x48 -> busy[1] set; overrun pulses exactly once at count 0x40 while ena_n_H=0.
- REQ-042 rst_n low at count 0x45 (TT) -> asynchronously ena_n_H=1 and cycle_cnt=0; after release, counting restarts at 0.
- REQ-043 sched_en low at count 0x50 -> IDLE next edge with all enables 1; sched_en high -> count 0, phase OPEN.
- REQ-044 With TT_GATE_OVERRUN_CNT_EN, force 300 overruns -> overrun_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/fpq_sched_pkg.sv
// fpq_sched_pkg: shared phase encodings, traffic-class codes and default counter width.
package fpq_sched_pkg;
  localparam int CW_DEF = 12;
  typedef enum logic [1:0] {
    PH_IDLE  = 2'b00,
    PH_OPEN  = 2'b01,
    PH_GUARD = 2'b10,
    PH_TT    = 2'b11
  } phase_e;
  localparam logic [1:0] TC_PCF = 2'b00;
  localparam logic [1:0] TC_TT  = 2'b01;
  localparam logic [1:0] TC_BE  = 2'b10;
  localparam logic [1:0] TC_RC  = 2'b11;
endpackage

// File: rtl/tt_gate_sched_cycle_timer.sv
// cycle_timer: schedule-cycle counter; restarts at 0 on the first enabled edge, holds 0 when disabled.
module cycle_timer #(
  parameter int             CW        = 12,
  parameter logic [CW-1:0]  CYCLE_LEN = 'h100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_cnt_nxt
);
  logic          r_run;
  logic [CW-1:0] r_cnt;
  assign o_cnt_nxt = (!i_en || !r_run || r_cnt == CYCLE_LEN - 1'b1) ? '0 : r_cnt + 1'b1;
  assign o_cnt     = r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else begin
      r_cnt <= o_cnt_nxt;
      r_run <= i_en;
    end
  end
endmodule

// File: rtl/tt_gate_sched.sv
// tt_gate_sched: time-triggered gate scheduler with guard band and low-priority busy tracking.
// Optional 8-bit saturating overrun counter enabled by macro TT_GATE_OVERRUN_CNT_EN.
module tt_gate_sched
  import fpq_sched_pkg::*;
#(
  parameter int            N_L       = 2,
  parameter int            CW        = CW_DEF,
  parameter logic [CW-1:0] CYCLE_LEN = 'h100,
  parameter logic [CW-1:0] TT_START  = 'h040,
  parameter logic [CW-1:0] TT_LEN    = 'h020,
  parameter logic [CW-1:0] GUARD     = 'h010
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sched_en,
  input  logic           bool_go_H,
  input  logic [N_L-1:0] bool_go_L,
  input  logic [N_L-1:0] done_L,
  output logic           ena_n_H,
  output logic [N_L-1:0] ena_n_L,
  output logic [1:0]     phase,
  output logic [CW-1:0]  cycle_cnt,
`ifdef TT_GATE_OVERRUN_CNT_EN
  output logic           overrun,
  output logic [7:0]     overrun_cnt
`else
  output logic           overrun
`endif
);
  if (!(({1'b0, GUARD} + {1'b0, TT_LEN}) < {1'b0, CYCLE_LEN} &&
        ({1'b0, TT_START} + {1'b0, TT_LEN}) <= {1'b0, CYCLE_LEN})) begin : g_bad_cfg
    $error("tt_gate_sched: GUARD+TT_LEN must be < CYCLE_LEN and TT_START+TT_LEN <= CYCLE_LEN");
  end
  logic [CW-1:0]  w_cnt_nxt;
  phase_e         w_state_nxt;
  logic [N_L-1:0] w_busy_nxt;
  logic           w_ovr;
  logic           w_unused_go_H;
  phase_e         r_state;
  logic [N_L-1:0] r_busy;
  logic           r_ena_n_H;
  logic [N_L-1:0] r_ena_n_L;
  logic           r_overrun;
  cycle_timer #(.CW(CW), .CYCLE_LEN(CYCLE_LEN)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (sched_en),
    .o_cnt     (cycle_cnt),
    .o_cnt_nxt (w_cnt_nxt)
  );
  // Guard distance is measured backwards from TT_START so the band may wrap past count 0.
  function automatic phase_e phase_of(input logic [CW-1:0] c);
    logic [CW:0] d;
    d = (c <= TT_START) ? {1'b0, TT_START} - {1'b0, c}
                        : {1'b0, TT_START} + {1'b0, CYCLE_LEN} - {1'b0, c};
    return (c >= TT_START && {1'b0, c} < {1'b0, TT_START} + {1'b0, TT_LEN}) ? PH_TT :
           (d != '0 && d <= {1'b0, GUARD}) ? PH_GUARD : PH_OPEN;
  endfunction
  always_comb begin
    w_state_nxt = sched_en ? phase_of(w_cnt_nxt) : PH_IDLE;
    w_busy_nxt  = (r_busy & ~done_L) | bool_go_L;
    w_ovr       = w_state_nxt == PH_TT && r_state != PH_TT && |w_busy_nxt;
  end
  assign w_unused_go_H = bool_go_H;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= PH_IDLE;
      r_busy    <= '0;
      r_ena_n_H <= 1'b1;
      r_ena_n_L <= '1;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= w_busy_nxt;
      r_ena_n_H <= w_state_nxt != PH_TT;
      r_ena_n_L <= w_state_nxt == PH_OPEN  ? '0 :
                   w_state_nxt == PH_GUARD ? ~w_busy_nxt : '1;
      r_overrun <= w_ovr;
    end
  end
  assign phase   = r_state;
  assign ena_n_H = r_ena_n_H;
  assign ena_n_L = r_ena_n_L;
  assign overrun = r_overrun;
`ifdef TT_GATE_OVERRUN_CNT_EN
  logic [7:0] r_ovr_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovr_cnt <= '0;
    else if (w_ovr && r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
  end
  assign overrun_cnt = r_ovr_cnt;
`endif
endmodule

// File: tb/tb_tt_gate_sched.sv
// tb_tt_gate_sched: table-driven checks of phase, enables and overrun plus reset/sched_en sequences.
module tb_tt_gate_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sched_en = 1'b0;
  logic        bool_go_H = 1'b0;
  logic [1:0]  bool_go_L = '0;
  logic [1:0]  done_L = '0;
  logic        ena_n_H;
  logic [1:0]  ena_n_L;
  logic [1:0]  phase;
  logic [11:0] cycle_cnt;
  logic        overrun;
`ifdef TT_GATE_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif
  int n_chk = 0;
  int n_err = 0;

  tt_gate_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sched_en  (sched_en),
    .bool_go_H (bool_go_H),
    .bool_go_L (bool_go_L),
    .done_L    (done_L),
    .ena_n_H   (ena_n_H),
    .ena_n_L   (ena_n_L),
    .phase     (phase),
    .cycle_cnt (cycle_cnt),
`ifdef TT_GATE_OVERRUN_CNT_EN
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
`else
    .overrun   (overrun)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] c;
    logic [1:0]  go;
    logic [1:0]  dn;
    logic        gh;
    logic [1:0]  ph;
    logic        eh;
    logic [1:0]  el;
    logic        ov;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cnt=%h)", name, act, exp, cycle_cnt);
    end
  endtask

  task automatic wait_cnt(input logic [11:0] c);
    int n = 0;
    while (cycle_cnt !== c && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (cycle_cnt !== c) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_cnt timeout: got %h expected %h", cycle_cnt, c);
    end
  endtask

  task automatic chk_state(input string name, input logic [1:0] ph, input logic eh,
                           input logic [1:0] el, input logic ov);
    chk({name, ".phase"}, 32'(phase), 32'(ph));
    chk({name, ".ena_n_H"}, 32'(ena_n_H), 32'(eh));
    chk({name, ".ena_n_L"}, 32'(ena_n_L), 32'(el));
    chk({name, ".overrun"}, 32'(overrun), 32'(ov));
  endtask

  initial begin
    // Inputs are driven during the cycle before count c, outputs checked while cycle_cnt == c.
    //           c        go     dn     gh    phase  eh   el     ov
    v.push_back('{12'h001, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0});
    v.push_back('{12'h02F, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0});
    v.push_back('{12'h030, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 2'b11, 1'b0});
    v.push_back('{12'h03F, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 2'b11, 1'b0});
    v.push_back('{12'h040, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 2'b11, 1'b0});
    v.push_back('{12'h05F, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 2'b11, 1'b0});
    v.push_back('{12'h060, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0});
    v.push_back('{12'h0FF, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0});
    v.push_back('{12'h000, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0});
    v.push_back('{12'h020, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0});
    v.push_back('{12'h030, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 2'b10, 1'b0});
    v.push_back('{12'h037, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 2'b10, 1'b0});
    v.push_back('{12'h038, 2'b00, 2'b01, 1'b0, 2'b10, 1'b1, 2'b11, 1'b0});
    v.push_back('{12'h040, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 2'b11, 1'b0});
    v.push_back('{12'h03C, 2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 2'b01, 1'b0});
    v.push_back('{12'h03F, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 2'b01, 1'b0});
    v.push_back('{12'h040, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 2'b11, 1'b1});
    v.push_back('{12'h041, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 2'b11, 1'b0});
    v.push_back('{12'h048, 2'b00, 2'b10, 1'b0, 2'b11, 1'b0, 2'b11, 1'b0});
    v.push_back('{12'h060, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0});
    v.push_back('{12'h034, 2'b01, 2'b00, 1'b0, 2'b10, 1'b1, 2'b10, 1'b0});
    v.push_back('{12'h038, 2'b00, 2'b01, 1'b0, 2'b10, 1'b1, 2'b11, 1'b0});
    v.push_back('{12'h039, 2'b01, 2'b01, 1'b0, 2'b10, 1'b1, 2'b10, 1'b0});
    v.push_back('{12'h03A, 2'b00, 2'b01, 1'b0, 2'b10, 1'b1, 2'b11, 1'b0});
    v.push_back('{12'h03B, 2'b00, 2'b10, 1'b1, 2'b10, 1'b1, 2'b11, 1'b0});
    v.push_back('{12'h040, 2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 2'b11, 1'b0});

    #1 rst_n = 1'b0;
    #1;
    chk("rst.cycle_cnt", 32'(cycle_cnt), 32'h0);
    chk_state("rst", 2'b00, 1'b1, 2'b11, 1'b0);
`ifdef TT_GATE_OVERRUN_CNT_EN
    chk("rst.overrun_cnt", 32'(overrun_cnt), 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold.phase", 32'(phase), 32'h0);
    rst_n = 1'b1;
    sched_en = 1'b1;
    @(negedge clk);
    chk("start.cycle_cnt", 32'(cycle_cnt), 32'h0);
    chk_state("start", 2'b01, 1'b1, 2'b00, 1'b0);

    for (int i = 0; i < v.size(); i++) begin
      wait_cnt(v[i].c == 12'h000 ? 12'h0FF : v[i].c - 12'h001);
      bool_go_L = v[i].go;
      done_L    = v[i].dn;
      bool_go_H = v[i].gh;
      @(negedge clk);
      bool_go_L = '0;
      done_L    = '0;
      bool_go_H = 1'b0;
      chk($sformatf("vec%0d.cycle_cnt", i), 32'(cycle_cnt), 32'(v[i].c));
      chk_state($sformatf("vec%0d", i), v[i].ph, v[i].eh, v[i].el, v[i].ov);
    end

    // Reset in the middle of TT with a low transfer in flight.
    wait_cnt(12'h043);
    bool_go_L = 2'b01;
    @(negedge clk);
    bool_go_L = '0;
    wait_cnt(12'h045);
    chk_state("pre_rst", 2'b11, 1'b0, 2'b11, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst.cycle_cnt", 32'(cycle_cnt), 32'h0);
    chk_state("async_rst", 2'b00, 1'b1, 2'b11, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release.cycle_cnt", 32'(cycle_cnt), 32'h0);
    chk_state("rst_release", 2'b01, 1'b1, 2'b00, 1'b0);
    @(negedge clk);
    chk("rst_release2.cycle_cnt", 32'(cycle_cnt), 32'h1);
    wait_cnt(12'h030);
    chk("busy_cleared.ena_n_L", 32'(ena_n_L), 32'h3);
`ifdef TT_GATE_OVERRUN_CNT_EN
    chk("post_rst.overrun_cnt", 32'(overrun_cnt), 32'h0);
`endif

    // sched_en drop during TT, then restart.
    wait_cnt(12'h050);
    sched_en = 1'b0;
    @(negedge clk);
    chk("idle.cycle_cnt", 32'(cycle_cnt), 32'h0);
    chk_state("idle", 2'b00, 1'b1, 2'b11, 1'b0);
    @(negedge clk);
    chk("idle_hold.cycle_cnt", 32'(cycle_cnt), 32'h0);
    chk("idle_hold.phase", 32'(phase), 32'h0);
    sched_en = 1'b1;
    @(negedge clk);
    chk("resume.cycle_cnt", 32'(cycle_cnt), 32'h0);
    chk_state("resume", 2'b01, 1'b1, 2'b00, 1'b0);
    @(negedge clk);
    chk("resume2.cycle_cnt", 32'(cycle_cnt), 32'h1);

`ifdef TT_GATE_OVERRUN_CNT_EN
    // Channel 0 held busy so every TT entry is an overrun.
    bool_go_L = 2'b01;
    for (int k = 0; k < 300; k++) begin
      wait_cnt(12'h040);
      if (k == 0) chk("ovr_first.overrun", 32'(overrun), 32'h1);
      wait_cnt(12'h041);
      if (k == 0) chk("ovr_first.overrun_cnt", 32'(overrun_cnt), 32'h1);
    end
    bool_go_L = '0;
    chk("ovr_sat.overrun_cnt", 32'(overrun_cnt), 32'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
